// File: rtl/spi_ip_clock_gen_if.sv
// Control-side bundle for the SPI clock generator: enables and frame config in,
// SCK and shift-register strobes out.
interface spi_ip_clock_gen_if #(
  parameter int BR_WIDTH = 3
);
  logic                cg_enable_tick_i;
  logic                cg_enable_sck_i;
  logic                cg_enable_launch_capture_i;
  logic [BR_WIDTH-1:0] cg_br_i;
  logic                cg_cpol_i;
  logic                cg_cpha_i;
  logic                cg_frame16_i;
  logic                cg_tick_o;
  logic                cg_sck_o;
  logic                cg_launch_o;
  logic                cg_capture_o;
  logic                cg_data_ready_o;

  modport master (
    output cg_enable_tick_i, cg_enable_sck_i, cg_enable_launch_capture_i,
           cg_br_i, cg_cpol_i, cg_cpha_i, cg_frame16_i,
    input  cg_tick_o, cg_sck_o, cg_launch_o, cg_capture_o, cg_data_ready_o
  );

  modport slave (
    input  cg_enable_tick_i, cg_enable_sck_i, cg_enable_launch_capture_i,
           cg_br_i, cg_cpol_i, cg_cpha_i, cg_frame16_i,
    output cg_tick_o, cg_sck_o, cg_launch_o, cg_capture_o, cg_data_ready_o
  );
endinterface

// File: rtl/spi_ip_clock_gen.sv
// SPI master timing generator: baud prescaler, SCK edge counter with CPOL/CPHA
// shaping, and launch/capture/data_ready strobes for the shift register.
module spi_ip_clock_gen #(
  parameter int BR_WIDTH       = 3,
  parameter int EDGE_CNT_WIDTH = 5
) (
  input  logic               cg_clk_i,
  input  logic               cg_rst_i,
  spi_ip_clock_gen_if.slave  cg
);
  localparam int PW = (1 << BR_WIDTH) - 1;
  // One extra bit so the 16-bit terminal count (32) is representable.
  localparam int CW = EDGE_CNT_WIDTH + 1;

  logic [BR_WIDTH-1:0] br_q, br_d;
  logic [PW-1:0]       presc_q, presc_d, presc_max;
  logic [CW-1:0]       edge_cnt_q, edge_cnt_d, term;
  logic                sck_q, sck_d;
  logic                tick, below_t, below_t1, odd_edge;
  logic                launch, capture, data_ready;

  always_comb begin
    br_d      = cg.cg_enable_tick_i ? br_q : cg.cg_br_i;
    presc_max = ~({PW{1'b1}} << br_q);
    tick      = ~cg_rst_i & cg.cg_enable_tick_i & (presc_q == presc_max);

    presc_d = '0;
    if (cg.cg_enable_tick_i && (presc_q != presc_max)) presc_d = presc_q + PW'(1);

    term     = cg.cg_frame16_i ? CW'(32) : CW'(16);
    below_t  = edge_cnt_q < term;
    below_t1 = edge_cnt_q < (term - CW'(1));
    // Upcoming edge k = edge_cnt_q + 1, so k is odd when the count is even.
    odd_edge = ~edge_cnt_q[0];

    edge_cnt_d = edge_cnt_q;
    if (!cg.cg_enable_sck_i)   edge_cnt_d = '0;
    else if (tick && below_t)  edge_cnt_d = edge_cnt_q + CW'(1);

    sck_d = cg.cg_cpol_i ^ edge_cnt_d[0];

    capture = tick & cg.cg_enable_sck_i & below_t & (odd_edge ^ cg.cg_cpha_i);
    if (cg.cg_enable_sck_i)
      launch = tick & cg.cg_enable_launch_capture_i & below_t1 & ~(odd_edge ^ cg.cg_cpha_i);
    else
      launch = tick & cg.cg_enable_launch_capture_i & ~cg.cg_cpha_i & (edge_cnt_q == '0);
    data_ready = tick & cg.cg_enable_sck_i & (edge_cnt_q == (term - CW'(2)));
  end

  always_ff @(posedge cg_clk_i) begin
    if (cg_rst_i) begin
      br_q       <= '0;
      presc_q    <= '0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
    end else begin
      br_q       <= br_d;
      presc_q    <= presc_d;
      edge_cnt_q <= edge_cnt_d;
      sck_q      <= sck_d;
    end
  end

  assign cg.cg_tick_o       = tick;
  assign cg.cg_sck_o        = sck_q;
  assign cg.cg_launch_o     = launch;
  assign cg.cg_capture_o    = capture;
  assign cg.cg_data_ready_o = data_ready;
endmodule

// File: tb/tb_spi_ip_clock_gen.sv
// Bench for spi_ip_clock_gen: prescaler vectors, a table of SPI frame modes
// checked through a per-tick strobe scoreboard, plus abort and reset sequences.
module tb_spi_ip_clock_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ip_clock_gen_if #(.BR_WIDTH(3)) cg_if ();
  spi_ip_clock_gen #(.BR_WIDTH(3), .EDGE_CNT_WIDTH(5)) dut (
    .cg_clk_i (clk),
    .cg_rst_i (rst),
    .cg       (cg_if)
  );

  typedef struct packed { logic launch; logic capture; logic dr; } exp_t;
  typedef struct { logic cpol; logic cpha; logic f16; logic [2:0] br;
                   int exp_launch; int exp_capture; int exp_toggles; } frame_vec_t;
  typedef struct { logic [2:0] br; int period; } presc_vec_t;

  exp_t sb_q[$];
  int   n_tests = 0, n_fail = 0;
  int   nl, nc, nd, ntog;
  logic sck_prev;
  bit   sb_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every tick pops one expected strobe set.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (cg_if.cg_sck_o !== sck_prev) ntog++;
      sck_prev = cg_if.cg_sck_o;
      if (cg_if.cg_launch_o)     nl++;
      if (cg_if.cg_capture_o)    nc++;
      if (cg_if.cg_data_ready_o) nd++;
      if (cg_if.cg_tick_o) begin
        if (sb_q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("launch",     cg_if.cg_launch_o,     e.launch);
          check("capture",    cg_if.cg_capture_o,    e.capture);
          check("data_ready", cg_if.cg_data_ready_o, e.dr);
        end
      end else begin
        check("stray_strobe", cg_if.cg_launch_o | cg_if.cg_capture_o | cg_if.cg_data_ready_o, 0);
      end
    end
  end

  function automatic exp_t exp_edge(input int k, input int t, input logic pha, input logic lc);
    exp_t e;
    e.capture = (k <= t) && (((k % 2) == 1) != pha);
    e.launch  = lc && (k < t) && (((k % 2) == 0) != pha);
    e.dr      = (k == t - 1);
    return e;
  endfunction

  task automatic do_tick(input exp_t e, input logic exp_sck);
    int n = 0;
    sb_q.push_back(e);
    @(negedge clk);
    while (!cg_if.cg_tick_o && n < 300) begin @(negedge clk); n++; end
    if (!cg_if.cg_tick_o) begin
      check("tick_timeout", 0, 1);
      sb_q.delete();
      return;
    end
    step();
    check("sck_after_tick", cg_if.cg_sck_o, exp_sck);
  endtask

  task automatic frame_setup(input logic pol, input logic pha, input logic f16, input logic [2:0] b);
    cg_if.cg_enable_tick_i = 0; cg_if.cg_enable_sck_i = 0; cg_if.cg_enable_launch_capture_i = 0;
    cg_if.cg_cpol_i = pol; cg_if.cg_cpha_i = pha; cg_if.cg_frame16_i = f16; cg_if.cg_br_i = b;
    step(); step();
    check("idle_sck", cg_if.cg_sck_o, pol);
    nl = 0; nc = 0; nd = 0; ntog = 0;
    sck_prev = cg_if.cg_sck_o;
    sb_on = 1'b1;
    cg_if.cg_enable_tick_i = 1; cg_if.cg_enable_launch_capture_i = 1;
    do_tick(exp_t'{launch: ~pha, capture: 1'b0, dr: 1'b0}, pol);
    cg_if.cg_enable_sck_i = 1;
  endtask

  task automatic frame_end();
    cg_if.cg_enable_tick_i = 0; cg_if.cg_enable_sck_i = 0; cg_if.cg_enable_launch_capture_i = 0;
    step(); step();
    sb_on = 1'b0;
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic run_frame(input frame_vec_t v);
    int t;
    t = v.f16 ? 32 : 16;
    frame_setup(v.cpol, v.cpha, v.f16, v.br);
    // Edges 1..T, then five saturated ticks with enable_sck still high.
    for (int k = 1; k <= t + 5; k++) begin
      do_tick(exp_edge(k, t, v.cpha, cg_if.cg_enable_launch_capture_i),
              v.cpol ^ (((k < t) ? k : t) % 2 == 1));
      if (k == t - 1) cg_if.cg_enable_launch_capture_i = 0;
    end
    frame_end();
    check("launch_count",  nl,   v.exp_launch);
    check("capture_count", nc,   v.exp_capture);
    check("dr_count",      nd,   1);
    check("sck_toggles",   ntog, v.exp_toggles);
  endtask

  task automatic cycles_to_tick(output int c);
    c = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (cg_if.cg_tick_o) begin c = i; step(); return; end
      step();
    end
    c = -1;
  endtask

  frame_vec_t fv[4];
  presc_vec_t pv[4];

  initial begin
    int c;
    fv[0] = '{cpol: 0, cpha: 0, f16: 0, br: 3'd0, exp_launch: 8,  exp_capture: 8,  exp_toggles: 16};
    fv[1] = '{cpol: 1, cpha: 1, f16: 1, br: 3'd1, exp_launch: 16, exp_capture: 16, exp_toggles: 32};
    fv[2] = '{cpol: 0, cpha: 1, f16: 0, br: 3'd2, exp_launch: 8,  exp_capture: 8,  exp_toggles: 16};
    fv[3] = '{cpol: 1, cpha: 0, f16: 1, br: 3'd0, exp_launch: 16, exp_capture: 16, exp_toggles: 32};
    pv[0] = '{br: 3'd0, period: 1};
    pv[1] = '{br: 3'd1, period: 2};
    pv[2] = '{br: 3'd3, period: 8};
    pv[3] = '{br: 3'd7, period: 128};

    // Reset with every enable high: strobes must stay quiet and SCK low.
    rst = 1;
    cg_if.cg_enable_tick_i = 1; cg_if.cg_enable_sck_i = 1; cg_if.cg_enable_launch_capture_i = 1;
    cg_if.cg_br_i = 0; cg_if.cg_cpol_i = 0; cg_if.cg_cpha_i = 0; cg_if.cg_frame16_i = 0;
    step(); step();
    @(negedge clk);
    check("rst_tick",    cg_if.cg_tick_o,       0);
    check("rst_launch",  cg_if.cg_launch_o,     0);
    check("rst_capture", cg_if.cg_capture_o,    0);
    check("rst_dr",      cg_if.cg_data_ready_o, 0);
    check("rst_sck",     cg_if.cg_sck_o,        0);
    step();
    cg_if.cg_enable_tick_i = 0; cg_if.cg_enable_sck_i = 0; cg_if.cg_enable_launch_capture_i = 0;
    cg_if.cg_cpol_i = 1;
    rst = 0;
    step();
    check("sck_tracks_cpol", cg_if.cg_sck_o, 1);
    cg_if.cg_cpol_i = 0;

    // Prescaler period table: first and second tick spacing.
    foreach (pv[i]) begin
      cg_if.cg_br_i = pv[i].br; cg_if.cg_enable_tick_i = 0;
      step();
      cg_if.cg_enable_tick_i = 1;
      cycles_to_tick(c); check("presc_first",  c, pv[i].period);
      cycles_to_tick(c); check("presc_second", c, pv[i].period);
      cg_if.cg_enable_tick_i = 0;
      step();
    end

    // br=2 for 20 cycles; a br change to 5 mid-run must be ignored.
    cg_if.cg_br_i = 3'd2;
    step();
    cg_if.cg_enable_tick_i = 1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 10) cg_if.cg_br_i = 3'd5;
      @(negedge clk);
      check("presc_br2", cg_if.cg_tick_o, (cyc % 4) == 0);
      step();
    end
    cg_if.cg_enable_tick_i = 0;
    step();

    foreach (fv[i]) run_frame(fv[i]);

    // Abort after edge 5, then restart: first edge must be edge 1 again.
    frame_setup(0, 0, 0, 3'd0);
    for (int k = 1; k <= 5; k++) do_tick(exp_edge(k, 16, 0, 1), (k % 2) == 1);
    cg_if.cg_enable_sck_i = 0; cg_if.cg_enable_launch_capture_i = 0;
    do_tick(exp_t'{launch: 1'b0, capture: 1'b0, dr: 1'b0}, 0);
    cg_if.cg_enable_sck_i = 1; cg_if.cg_enable_launch_capture_i = 1;
    do_tick(exp_edge(1, 16, 0, 1), 1);
    frame_end();

    // Reset in the edge-9 cycle of a 16-bit CPOL=1 frame.
    frame_setup(1, 0, 1, 3'd0);
    for (int k = 1; k <= 8; k++) do_tick(exp_edge(k, 32, 0, 1), 1'b1 ^ ((k % 2) == 1));
    rst = 1;
    @(negedge clk);
    check("midrst_tick",    cg_if.cg_tick_o,       0);
    check("midrst_launch",  cg_if.cg_launch_o,     0);
    check("midrst_capture", cg_if.cg_capture_o,    0);
    check("midrst_dr",      cg_if.cg_data_ready_o, 0);
    step();
    check("midrst_sck", cg_if.cg_sck_o, 0);
    cg_if.cg_enable_tick_i = 0; cg_if.cg_enable_sck_i = 0; cg_if.cg_enable_launch_capture_i = 0;
    rst = 0;
    step();
    check("postrst_sck", cg_if.cg_sck_o, 1);
    cg_if.cg_enable_tick_i = 1; cg_if.cg_enable_sck_i = 1;
    do_tick(exp_edge(1, 32, 0, 0), 0);
    frame_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule

// File: doc/spi_ip_clock_gen.md
Name: spi_ip_clock_gen

Overview:
Master-mode timing generator feeding the SPI control unit and shift register.
- Divides the system clock into half-SCK "ticks".
- Drives SCK with CPOL/CPHA shaping.
- Issues launch/capture strobes to the shift register.
- Flags the last data capture of a frame (data_ready), which the control FSM uses to leave its TX/RX state.
- Consumes the control unit's enable_tick, enable_sck and enable_launch_capture outputs.

Parameters:
- BR_WIDTH, 3, width of baud-rate select. Half SCK period = 2^cg_br_i system clocks.
- EDGE_CNT_WIDTH, 5, width of the SCK edge counter. Must hold 32.

Ports:
- cg_clk_i  in  1  system clock
- cg_rst_i  in  1  synchronous, active-high reset
- cg_enable_tick_i  in  1  run prescaler
- cg_enable_sck_i  in  1  allow SCK edges and captures
- cg_enable_launch_capture_i  in  1  allow launch strobes
- cg_br_i  in  BR_WIDTH  baud select
- cg_cpol_i  in  1  SCK idle level
- cg_cpha_i  in  1  0: capture on odd edges; 1: capture on even edges
- cg_frame16_i  in  1  0: 8-bit frame; 1: 16-bit frame
- cg_tick_o  out  1  one-cycle half-period strobe
- cg_sck_o  out  1  registered SCK
- cg_launch_o  out  1  one-cycle "shift out next bit" strobe
- cg_capture_o  out  1  one-cycle "sample MISO" strobe
- cg_data_ready_o  out  1  one-cycle "frame's final tick-before-trailing-edge" strobe

Behaviour:
- Reset (cg_rst_i=1, sampled at posedge):
  - Prescaler = 0, br_q = 0, edge_cnt = 0, cg_sck_o = 0.
  - All strobes are forced 0 while cg_rst_i=1.
  - From the first cycle after reset, cg_sck_o tracks cg_cpol_i when idle.
- Prescaler:
  - presc_max = 2^br_q - 1, range 0..127.
  - br_q loads cg_br_i on every cycle with cg_enable_tick_i=0 and is frozen while it is 1. A br change mid-transfer is ignored.
  - Counter clears when enable_tick=0.
  - When enable_tick=1, counter increments and wraps to 0 at presc_max.
  - cg_tick_o = enable_tick & (presc == presc_max), combinational.
  - br=0 gives a tick every cycle. The first tick comes 2^br cycles after enable_tick rises.
- Edge counter:
  - N = 8 or 16 (frame16). Terminal count T = 2N.
  - Clears when enable_sck=0.
  - Increments on tick when enable_sck=1 and edge_cnt<T. Saturates at T.
  - The tick with edge_cnt=k-1 is SCK edge k (1-based).
- SCK:
  - Next-state value = cpol XOR edge_cnt_next[0], where edge_cnt_next is the value loaded this cycle.
  - Idle (enable_sck=0) and terminal (edge_cnt=T) levels equal cpol.
- Strobes (combinational, all require cg_tick_o):
  - capture = enable_sck & edge_cnt<T & (edge k odd when cpha=0, even when cpha=1).
  - launch when enable_sck=1: enable_launch_capture & edge_cnt<T-1 & (edge k even when cpha=0, odd when cpha=1).
  - launch when enable_sck=0 (setup pre-launch): enable_launch_capture & cpha=0 & edge_cnt=0.
  - data_ready = enable_sck & edge_cnt=T-2, i.e. edge T-1. The control FSM moves to its LSB state, whose single tick produces edge T.
  - Resulting counts for CPHA=0, N=8: 1 pre-launch + 7 launches (edges 2..14), 8 captures (1..15).
  - Resulting counts for CPHA=1: 8 launches (edges 1..15), 8 captures (2..16). The last capture occurs in the LSB state.
- Boundaries and simultaneous events:
  - enable_sck falls mid-frame: edge_cnt=0 and SCK=cpol on the next cycle. No strobes while enable_sck=0 except the pre-launch.
  - enable_tick falls: prescaler clears. Edge count is held unless enable_sck is also 0.
  - Reset asserted mid-frame overrides all enables the same cycle.
  - Ticks after edge_cnt=T produce no SCK toggle, capture, launch or data_ready.
  - cpol, cpha and frame16 must be stable while enable_tick=1. Behaviour on change is undefined.

Test Plan:
- Prescaler: br=2, enable_tick held high 20 cycles -> cg_tick_o pulses at cycles 4, 8, 12, 16, 20. Change br to 5 at cycle 10 -> spacing stays 4.
- Mode 0, 8-bit, br=0: one setup tick with enable_launch_capture=1, then enable_sck=1 with launch_capture=1 until data_ready, then one more tick with launch_capture=0 ->
  - SCK shows 16 edges, idle 0.
  - 1 pre-launch, 7 launches, 8 captures.
  - data_ready coincides with the 8th capture (edge 15).
  - SCK returns to 0 at edge 16.
- Mode 3 (cpol=1, cpha=1), 16-bit, br=1 -> SCK idle 1, 32 edges at 2-cycle spacing, 16 launches on odd edges, 16 captures on even edges, no pre-launch, data_ready at edge 31.
- Abort: mode 0 frame, drop enable_sck after edge 5 -> next cycle sck_o=cpol. Re-enable -> next edge is edge 1 (capture).
- Reset mid-frame: assert cg_rst_i at edge 9 of a 16-bit frame ->
  - Same cycle: all strobes 0.
  - Next cycle: sck_o=0, counters 0.
  - After release with cpol=1, sck_o=1.
- Saturation: hold enable_sck=1 for 5 extra ticks after edge T -> no SCK toggles, no strobes, edge_cnt stays at T.
